// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: transaction source, tracker entry
// and the width of the fetch starvation counter.
package mem_arb_pkg;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } mem_src_e;

   typedef struct packed {
      mem_src_e src;
      logic     drop;
   } txn_entry_t;

   localparam int FETCH_MAX_WAIT_LIMIT = 15;
   localparam int STARVE_CNT_W         = $clog2(FETCH_MAX_WAIT_LIMIT + 1);

endpackage

// File: rtl/mem_arb_txn_fifo.sv
// In-order ring buffer of in-flight memory transactions, with a broadcast that
// marks every fetch entry as stale so its response is discarded on return.
module mem_arb_txn_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  txn_entry_t       push_entry_i,
   input  logic             pop_i,
   input  logic             mark_drop_i,
   output txn_entry_t       head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   txn_entry_t       entries_q [DEPTH];
   txn_entry_t       entries_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = entries_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Next-state: drop marking, push, pop and occupancy.
   // Stale slots may also get marked; a push overwrites the whole entry anyway.
   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (mark_drop_i && (entries_q[i].src == SRC_INSTR)) begin
            entries_d[i].drop = 1'b1;
         end else begin
            entries_d[i].drop = entries_q[i].drop;
         end
      end
      if (push_ok) begin
         entries_d[wr_ptr_q] = push_entry_i;
         wr_ptr_d            = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   // Tracker state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         entries_q <= entries_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between fetch and LSU: same-cycle request
// forwarding, locked arbitration with fetch anti-starvation, in-order routing.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int FETCH_MAX_WAIT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   input  logic        instr_flush_i,
   output logic        busy_o,
   output logic        proto_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(FETCH_MAX_WAIT);

   logic                    lock_active_q, lock_active_d;
   mem_src_e                lock_src_q, lock_src_d;
   logic [STARVE_CNT_W-1:0] starve_q, starve_d;
   logic                    proto_err_q, proto_err_d;
   mem_src_e                sel;
   txn_entry_t              push_entry;
   txn_entry_t              head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic                    handshake;
   logic                    resp_pop;

   // Source selection: an ungranted request keeps its slot, then starvation, then LSU.
   always_comb begin
      if (lock_active_q) begin
         sel = lock_src_q;
      end else if ((starve_q == STARVE_MAX) && instr_req_i) begin
         sel = SRC_INSTR;
      end else if (data_req_i) begin
         sel = SRC_DATA;
      end else begin
         sel = SRC_INSTR;
      end
   end

   // Full blocks requests regardless of a same-cycle pop, keeping rvalid off the req path.
   assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
   assign handshake = mem_req_o & mem_gnt_i;

   // Request attributes from the selected source.
   always_comb begin
      case (sel)
         SRC_DATA: begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end
         default: begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0000_0000;
         end
      endcase
   end

   assign instr_gnt_o     = handshake & (sel == SRC_INSTR);
   assign data_gnt_o      = handshake & (sel == SRC_DATA);
   assign push_entry.src  = sel;
   assign push_entry.drop = instr_flush_i & (sel == SRC_INSTR);

   mem_arb_txn_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_txn_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (handshake),
      .push_entry_i (push_entry),
      .pop_i        (mem_rvalid_i),
      .mark_drop_i  (instr_flush_i),
      .head_o       (head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (fifo_count)
   );

   assign resp_pop       = mem_rvalid_i & ~fifo_empty;
   assign instr_rvalid_o = resp_pop & (head.src == SRC_INSTR) & ~head.drop & ~instr_flush_i;
   assign data_rvalid_o  = resp_pop & (head.src == SRC_DATA) & ~head.drop;
   assign rdata_o        = mem_rdata_i;
   assign err_o          = mem_err_i;
   assign busy_o         = (fifo_count != '0);
   assign proto_err_o    = proto_err_q;

   // Next-state for lock, starvation counter and sticky protocol error.
   always_comb begin
      lock_active_d = lock_active_q;
      lock_src_d    = lock_src_q;
      if (mem_gnt_i) begin
         lock_active_d = 1'b0;
      end else if (mem_req_o) begin
         lock_active_d = 1'b1;
         lock_src_d    = sel;
      end else begin
         lock_active_d = lock_active_q;
      end
      if (!instr_req_i || instr_gnt_o) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + STARVE_CNT_W'(1);
      end else begin
         starve_d = starve_q;
      end
      proto_err_d = proto_err_q | (mem_rvalid_i & fifo_empty);
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_active_q <= 1'b0;
         lock_src_q    <= SRC_INSTR;
         starve_q      <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         lock_active_q <= lock_active_d;
         lock_src_q    <= lock_src_d;
         starve_q      <= starve_d;
         proto_err_q   <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed sequences with literal expectations and a randomized phase.
module tb_mem_port_arbiter;

   localparam int MAXO = 2;
   localparam int FMW  = 4;

   logic        clk;
   logic        rst;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   logic        instr_flush_i;
   logic        busy_o;
   logic        proto_err_o;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(
      .MAX_OUTSTANDING (MAXO),
      .FETCH_MAX_WAIT  (FMW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .instr_flush_i  (instr_flush_i),
      .busy_o         (busy_o),
      .proto_err_o    (proto_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: transactions in flight as a queue (src 0 = fetch, 1 = data).
   typedef struct {
      bit src;
      bit drop;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_starve;
   bit     m_lock_v;
   bit     m_lock_src;
   bit     m_perr;

   initial begin : compare
      bit     full, sel, e_req, e_ig, e_dg, e_irv, e_drv;
      m_ent_t ne;
      m_starve   = 0;
      m_lock_v   = 1'b0;
      m_lock_src = 1'b0;
      m_perr     = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
            m_starve   = 0;
            m_lock_v   = 1'b0;
            m_lock_src = 1'b0;
            m_perr     = 1'b0;
            chk1("busy_in_reset", busy_o, 1'b0);
            chk1("proto_in_reset", proto_err_o, 1'b0);
         end else begin
            full = (mq.size() == MAXO);
            if (m_lock_v) sel = m_lock_src;
            else if (m_starve == FMW && instr_req_i) sel = 1'b0;
            else if (data_req_i) sel = 1'b1;
            else sel = 1'b0;
            e_req = (instr_req_i || data_req_i) && !full;
            e_ig  = e_req && mem_gnt_i && !sel;
            e_dg  = e_req && mem_gnt_i && sel;
            e_irv = 1'b0;
            e_drv = 1'b0;
            if (mem_rvalid_i && mq.size() > 0) begin
               if (mq[0].src) e_drv = !mq[0].drop;
               else e_irv = !mq[0].drop && !instr_flush_i;
            end
            chk1("mem_req", mem_req_o, e_req);
            chk1("instr_gnt", instr_gnt_o, e_ig);
            chk1("data_gnt", data_gnt_o, e_dg);
            chk1("instr_rvalid", instr_rvalid_o, e_irv);
            chk1("data_rvalid", data_rvalid_o, e_drv);
            chk1("busy", busy_o, mq.size() != 0);
            chk1("proto_err", proto_err_o, m_perr);
            if (e_req) begin
               chk32("mem_addr", mem_addr_o, sel ? data_addr_i : instr_addr_i);
               chk1("mem_we", mem_we_o, sel ? data_we_i : 1'b0);
               chk32("mem_be", {28'h0, mem_be_o}, {28'h0, sel ? data_be_i : 4'hF});
               if (sel) chk32("mem_wdata", mem_wdata_o, data_wdata_i);
            end
            if (e_irv || e_drv) begin
               chk32("rdata", rdata_o, mem_rdata_i);
               chk1("err", err_o, mem_err_i);
            end
            if (mem_rvalid_i) begin
               if (mq.size() > 0) void'(mq.pop_front());
               else m_perr = 1'b1;
            end
            if (instr_flush_i) begin
               foreach (mq[i]) if (!mq[i].src) mq[i].drop = 1'b1;
            end
            if (e_req && mem_gnt_i) begin
               ne.src  = sel;
               ne.drop = instr_flush_i && !sel;
               mq.push_back(ne);
            end
            if (mem_gnt_i) m_lock_v = 1'b0;
            else if (e_req) begin
               m_lock_v   = 1'b1;
               m_lock_src = sel;
            end
            if (!instr_req_i || e_ig) m_starve = 0;
            else if (m_starve < FMW) m_starve++;
         end
      end
   end

   task automatic idle_inputs();
      instr_req_i   = 1'b0;
      instr_addr_i  = 32'h0;
      data_req_i    = 1'b0;
      data_we_i     = 1'b0;
      data_be_i     = 4'h0;
      data_addr_i   = 32'h0;
      data_wdata_i  = 32'h0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = 32'h0;
      mem_err_i     = 1'b0;
      instr_flush_i = 1'b0;
   endtask

   // One directed cycle: drive after the rising edge, return at the falling edge.
   task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input bit g, input bit rv,
                      input logic [31:0] rd, input bit fl);
      @(posedge clk);
      #1;
      instr_req_i   = ir;
      instr_addr_i  = ia;
      data_req_i    = dr;
      data_we_i     = dw;
      data_be_i     = dw ? 4'h3 : 4'hF;
      data_addr_i   = da;
      data_wdata_i  = ~da;
      mem_gnt_i     = g;
      mem_rvalid_i  = rv;
      mem_rdata_i   = rd;
      mem_err_i     = 1'b0;
      instr_flush_i = fl;
      @(negedge clk);
   endtask

   initial begin : stim
      bit [5:0] dg_pat;
      bit       ig_seen, dg_seen;
      int       pend;
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk1("rst_instr_gnt", instr_gnt_o, 1'b0);
      chk1("rst_data_gnt", data_gnt_o, 1'b0);
      chk1("rst_rvalid", instr_rvalid_o | data_rvalid_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_proto", proto_err_o, 1'b0);
      chk1("rst_mem_req", mem_req_o, 1'b0);

      // Fetch-only stream 0x0/0x4/0x8 with one-cycle response latency.
      cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("fs_gnt0", instr_gnt_o, 1'b1);
      chk32("fs_addr0", mem_addr_o, 32'h0);
      chk32("fs_be0", {28'h0, mem_be_o}, 32'hF);
      cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0000, 1'b0);
      chk1("fs_gnt1", instr_gnt_o, 1'b1);
      chk1("fs_rv1", instr_rvalid_o, 1'b1);
      chk32("fs_rdata1", rdata_o, 32'h1000_0000);
      cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0004, 1'b0);
      chk1("fs_gnt2", instr_gnt_o, 1'b1);
      chk1("fs_rv2", instr_rvalid_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0008, 1'b0);
      chk1("fs_rv3", instr_rvalid_o, 1'b1);
      chk32("fs_rdata3", rdata_o, 32'h1000_0008);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk1("fs_busy_end", busy_o, 1'b0);

      // Both request every cycle: data wins 4 times, then fetch is forced through.
      dg_pat = 6'b101111;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, k > 0, 32'hD0 + k, 1'b0);
         chk1("st_data_gnt", data_gnt_o, dg_pat[k]);
         chk1("st_instr_gnt", instr_gnt_o, !dg_pat[k]);
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD6, 1'b0);
      chk1("st_last_rv", data_rvalid_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk1("st_busy_end", busy_o, 1'b0);

      // Lock: data waits three cycles for grant while fetch starts requesting.
      for (int k = 0; k < 3; k++) begin
         cyc(k == 2, 32'h40, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0);
         chk32("lk_addr", mem_addr_o, 32'h2000);
         chk1("lk_we", mem_we_o, 1'b1);
         chk1("lk_instr_gnt", instr_gnt_o, 1'b0);
      end
      cyc(1'b1, 32'h40, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lk_data_gnt", data_gnt_o, 1'b1);
      chk1("lk_instr_gnt3", instr_gnt_o, 1'b0);
      chk32("lk_addr3", mem_addr_o, 32'h2000);
      cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0);
      chk1("lk_instr_gnt4", instr_gnt_o, 1'b1);
      chk1("lk_data_rv", data_rvalid_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0000, 1'b0);
      chk1("lk_instr_rv", instr_rvalid_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Tracker full with two fetches, flush, then a data read.
      cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("fl_gnt1", instr_gnt_o, 1'b1);
      cyc(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk1("fl_full_req", mem_req_o, 1'b0);
      chk1("fl_full_busy", busy_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1, 32'h55, 1'b0);
      chk1("fl_full_pop_req", mem_req_o, 1'b0);
      chk1("fl_drop0", instr_rvalid_o, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1, 32'h66, 1'b0);
      chk1("fl_drop1", instr_rvalid_o, 1'b0);
      chk1("fl_data_gnt", data_gnt_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b0);
      chk1("fl_data_rv", data_rvalid_o, 1'b1);
      chk32("fl_data_rdata", rdata_o, 32'h77);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk1("fl_busy_end", busy_o, 1'b0);

      // Flush coinciding with a fetch grant and a fetch response.
      cyc(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h88, 1'b1);
      chk1("fs2_gnt", instr_gnt_o, 1'b1);
      chk1("fs2_rv_sup", instr_rvalid_o, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0);
      chk1("fs2_rv_drop", instr_rvalid_o, 1'b0);
      chk1("fs2_busy", busy_o, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk1("fs2_busy_end", busy_o, 1'b0);

      // Response with nothing outstanding, then reset mid-transaction.
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEE, 1'b0);
      chk1("pe_no_rv", instr_rvalid_o | data_rvalid_o, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk1("pe_set", proto_err_o, 1'b1);
      cyc(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("pe_hold", proto_err_o, 1'b1);
      chk1("pe_gnt", instr_gnt_o, 1'b1);
      @(posedge clk);
      #3;
      idle_inputs();
      rst = 1'b1;
      #1;
      chk1("ar_busy", busy_o, 1'b0);
      chk1("ar_proto", proto_err_o, 1'b0);
      chk1("ar_gnt", instr_gnt_o | data_gnt_o, 1'b0);
      chk1("ar_rv", instr_rvalid_o | data_rvalid_o, 1'b0);
      chk1("ar_req", mem_req_o, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Randomized traffic against the model; requesters hold until granted.
      ig_seen = 1'b0;
      dg_seen = 1'b0;
      pend    = 0;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         if (n == 2000) begin
            idle_inputs();
            rst  = 1'b1;
            pend = 0;
            @(negedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
         end
         if (!instr_req_i || ig_seen) begin
            instr_req_i  = ($urandom_range(0, 99) < 60);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!data_req_i || dg_seen) begin
            data_req_i   = ($urandom_range(0, 99) < 50);
            data_we_i    = $urandom_range(0, 1) == 1;
            data_be_i    = 4'($urandom);
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
         end
         mem_gnt_i     = ($urandom_range(0, 99) < 70);
         mem_rvalid_i  = (pend > 0) && ($urandom_range(0, 99) < 55);
         mem_rdata_i   = $urandom;
         mem_err_i     = ($urandom_range(0, 99) < 10);
         instr_flush_i = ($urandom_range(0, 99) < 8);
         if (mem_rvalid_i) pend--;
         @(negedge clk);
         ig_seen = instr_gnt_o;
         dg_seen = data_gnt_o;
         if (mem_req_o && mem_gnt_i) pend++;
      end

      @(posedge clk);
      #1 idle_inputs();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
